mmu_join_sync_fifo: RTL and testbench
=====================================

# mmu_join_sync_fifo

Clocked consumer for the two-port wait-merge stage: accepts the merged click-protocol request (drive pulse plus bundled data from both ports), synchronizes it into the `clk` domain, and buffers the joined data in a FIFO toward the synchronous MMU walker. It returns the `free` pulse to the merge stage only once the entry has been committed. Upstream backpressure therefore equals FIFO fullness.

## Interface
Parameters:
- `DATA_W`, default 32: width of each port's bundled data.
- `DEPTH`, default 4: FIFO entries; must be a power of two and ≥2.

Ports:
- `clk`  input  1  single block clock.
- `rstn`  input  1  reset; asynchronous, active-low.
- `i_drive`  input  1  request click pulse from the merge stage's `o_driveNext`.
- `o_free`  output  1  acknowledge pulse to the merge stage's `i_freeNext`.
- `i_data0`  input  DATA_W  port-0 bundled data; stable from `i_drive` rise until `o_free`.
- `i_data1`  input  DATA_W  port-1 bundled data; same stability rule.
- `o_valid`  output  1  FIFO head valid.
- `i_ready`  input  1  consumer accepts head.
- `o_data`  output  2*DATA_W  head entry, packed `{data1,data0}`.
- `o_count`  output  clog2(DEPTH)+1  current occupancy.

## Operation
- **Request capture.** `r_reqTog` is a flop clocked by the `i_drive` rising edge and toggles on every request. It resets asynchronously to 0.
- **Synchronization.** `r_reqTog` is synchronized into `clk` by an N-flop chain; N is 2 by default. The synchronized value is `s_req`. `r_seen` holds the last accepted toggle value.
- **Request pending.** A request is pending when `s_req != r_seen`.
- **FSM states:**
  - `IDLE`: no pending request. Goes to `WRITE` when a request is pending.
  - `WRITE`: if `count < DEPTH` or a pop happens in this cycle, write `{i_data1,i_data0}` at `wr_ptr`, increment `wr_ptr`, set `r_seen <= s_req`, and go to `ACK`. Otherwise stay in `WRITE` (stall).
  - `ACK`: `o_free` = 1 for exactly one cycle, then go to `IDLE`.
- **Output side.** The FIFO is first-word-fall-through. `o_valid = (count != 0)` and `o_data = mem[rd_ptr]`.
  - A pop occurs when `o_valid & i_ready`. It increments `rd_ptr`.
- **Pointers.** Width is clog2(DEPTH). They wrap naturally modulo DEPTH.
- **Count.** `count` goes +1 on write only, −1 on pop only, and is unchanged when both happen in the same cycle.
- **Full with simultaneous pop.** The write is accepted and `count` stays at DEPTH.
- **Empty.** A pop is impossible because `o_valid` = 0. A write into an empty FIFO is visible on `o_valid` the cycle after the write.
- **Upstream contract.** Upstream issues no new `i_drive` before `o_free`, so at most one request is outstanding. A second toggle arriving early is a protocol violation and its behaviour is undefined.
- **Reset.** When `rstn` is asserted, all state clears: FSM = `IDLE`, pointers and count = 0, `r_seen` = 0, synchronizer = 0, `r_reqTog` = 0. Any in-flight request is dropped and no `o_free` is issued.

## Timing
- **Reset values:** `o_free` = 0, `o_valid` = 0, `o_data` = 0 (memory cleared), `o_count` = 0.
- **Drive-to-free latency, not full:** N synchronizer cycles + 1 (`WRITE`) + 1 (`ACK`). That is 4 cycles for N=2, ±1 cycle for edge phase.
- **Drive-to-valid latency, empty FIFO:** N + 2 cycles.
- **Stall.** When full, `o_free` is delayed by exactly the number of cycles until the first pop. The write then completes in the pop cycle.
- **`o_free` pulse width:** one `clk` period, which must exceed the merge stage's minimum pulse width.
- **Data sampling.** `i_data*` is sampled only in the `WRITE` cycle. By then the data has been stable for ≥N cycles.

## Configuration
- **`MMU_SYNC3_EN` defined:** the synchronizer is 3 flops (N=3). Drive-to-free latency is 5 cycles; drive-to-valid latency is 5 cycles.
- **Undefined:** N=2 (latencies 4 / 4). No other behaviour changes.

## Structure
- **Package `mmu_sync_pkg`:**
  - `MMU_SYNC_STAGES` constant, selected by the macro.
  - FSM state enum (`IDLE`/`WRITE`/`ACK`).
  - `cnt_w(DEPTH)` function returning clog2(DEPTH)+1.
- **Sub-module `mmu_sync_bit`:** parameterized N-flop synchronizer with async active-low reset. It is marked `dont_touch`.
- The toggle flop sits in the top level and is also marked `dont_touch`.

## Test plan
- **Single request:** reset, then one `i_drive` with data0=0x11, data1=0x22. Expect `o_free` pulse after 4 cycles (5 with macro), `o_data`=0x00000022_00000011, `o_count`=1.
- **Fill to full:** DEPTH=4, `i_ready`=0, five requests (each waiting for `o_free`). Expect 4 `o_free` pulses and `o_count`=4. The 5th request stalls with `o_free` low.
- **Release one stall:** from the full state, hold `i_ready` high for one cycle. Expect the 5th `o_free` within 2 cycles, `o_count` stays 4, and output order is first-in first-out.
- **Wrap-around:** 10 back-to-back requests with data = index and `i_ready`=1. Expect outputs 0..9 in order, pointer wrap after 4 entries, and `o_count` ≤ 1.
- **Reset mid-request:** assert `rstn` low one cycle after `i_drive`. Expect no `o_free`, `o_count`=0, `o_valid`=0, and a following request behaves as in the single-request case.

Source files
------------

// File: rtl/mmu_sync_pkg.sv
// Shared constants, FSM encoding and width helper for the join/sync FIFO.
// MMU_SYNC3_EN selects a 3-flop request synchronizer instead of 2.
package mmu_sync_pkg;

`ifdef MMU_SYNC3_EN
  localparam int MMU_SYNC_STAGES = 3;
`else
  localparam int MMU_SYNC_STAGES = 2;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } fsm_state_e;

  // Occupancy needs one extra bit so that a full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/mmu_sync_bit.sv
// Parameterised N-flop single-bit synchronizer with async active-low reset.
module mmu_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  (* dont_touch = "true" *) logic [STAGES-1:0] sync_r;

  // Shift the asynchronous bit through the metastability chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/mmu_join_sync_fifo.sv
// Click-protocol request receiver feeding a FWFT FIFO toward the MMU walker.
// Define MMU_SYNC3_EN for a 3-stage request synchronizer (default 2).
module mmu_join_sync_fifo
  import mmu_sync_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_drive,
  output logic                     o_free,
  input  logic [DATA_W-1:0]        i_data0,
  input  logic [DATA_W-1:0]        i_data1,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [2*DATA_W-1:0]      o_data,
  output logic [cnt_w(DEPTH)-1:0]  o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  (* dont_touch = "true" *) logic req_tog_r;
  logic                req_sync_s;
  logic                seen_r;
  logic                pending_s;
  logic                pop_s;
  logic                wr_en_s;
  logic                free_r;
  fsm_state_e          state_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [2*DATA_W-1:0] mem_r [DEPTH];

  // Each drive click flips the toggle; the clk domain detects the change.
  always_ff @(posedge i_drive or negedge rstn) begin
    if (!rstn) begin
      req_tog_r <= 1'b0;
    end else begin
      req_tog_r <= ~req_tog_r;
    end
  end

  mmu_sync_bit #(
    .STAGES (MMU_SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (req_tog_r),
    .q    (req_sync_s)
  );

  assign pending_s = (req_sync_s != seen_r);
  assign o_valid   = (count_r != CNT_W'(0));
  assign pop_s     = o_valid & i_ready;
  assign o_data    = mem_r[rd_ptr_r];
  assign o_count   = count_r;
  assign o_free    = free_r;

  // A full FIFO still accepts the write when the head is popped in the same cycle.
  always_comb begin
    wr_en_s = 1'b0;
    if ((state_r == WRITE) && ((count_r < FULL_CNT) || pop_s)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Request handshake FSM: wait for pending toggle, commit, then one-cycle free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= IDLE;
      seen_r  <= 1'b0;
      free_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          free_r <= 1'b0;
          if (pending_s) begin
            state_r <= WRITE;
          end else begin
            state_r <= IDLE;
          end
        end
        WRITE: begin
          if (wr_en_s) begin
            seen_r  <= req_sync_s;
            free_r  <= 1'b1;
            state_r <= ACK;
          end else begin
            free_r  <= 1'b0;
            state_r <= WRITE;
          end
        end
        ACK: begin
          free_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          free_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(2*DATA_W){1'b0}};
      end
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= {i_data1, i_data0};
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({wr_en_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_join_sync_fifo.sv
// Scoreboard bench for mmu_join_sync_fifo: directed requests, monitor-side data checks.
module tb_mmu_join_sync_fifo;

`ifdef MMU_SYNC3_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_drive;
  logic        o_free;
  logic [31:0] i_data0;
  logic [31:0] i_data1;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_data;
  logic [2:0]  o_count;

  int          checks = 0;
  int          fails  = 0;
  logic [63:0] exp_q [$];
  bit          wrap_phase = 1'b0;
  logic [2:0]  max_cnt = 3'd0;

  mmu_join_sync_fifo #(
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_drive (i_drive),
    .o_free  (o_free),
    .i_data0 (i_data0),
    .i_data1 (i_data1),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head is compared against the scoreboard queue.
  always @(negedge clk) begin
    if (wrap_phase && (o_count > max_cnt)) max_cnt = o_count;
    if (rstn && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL pop_unexpected: got %h required no output", o_data);
      end else begin
        check("pop_data", o_data, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [31:0] d0, input logic [31:0] d1, input bit push);
    @(posedge clk);
    #2;
    i_data0 = d0;
    i_data1 = d1;
    i_drive = 1'b1;
    if (push) exp_q.push_back({d1, d0});
    #2 i_drive = 1'b0;
  endtask

  task automatic wait_free(input int max_n, output int lat);
    lat = -1;
    for (int n = 0; n < max_n; n++) begin
      @(negedge clk);
      if (o_free) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic send(input logic [31:0] d0, input logic [31:0] d1);
    int lat;
    issue(d0, d1, 1'b1);
    wait_free(12, lat);
    check("free_latency", lat, LAT);
    @(negedge clk);
    check("free_width", o_free, 1'b0);
  endtask

  task automatic pop_cycles(input int n);
    @(posedge clk);
    #2 i_ready = 1'b1;
    repeat (n) @(posedge clk);
    #2 i_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit ok;
    int lat;
    rstn    = 1'b0;
    i_drive = 1'b0;
    i_data0 = 32'd0;
    i_data1 = 32'd0;
    i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    @(negedge clk);
    check("reset_free",  o_free,  1'b0);
    check("reset_valid", o_valid, 1'b0);
    check("reset_data",  o_data,  64'h0);
    check("reset_count", o_count, 3'd0);

    // Single request
    send(32'h11, 32'h22);
    check("single_count", o_count, 3'd1);
    check("single_valid", o_valid, 1'b1);
    check("single_data",  o_data,  64'h00000022_00000011);
    pop_cycles(1);
    @(negedge clk);
    check("single_drained", o_count, 3'd0);

    // Fill to full, then a stalled fifth request
    for (int i = 0; i < 4; i++) send(32'hA0 + i, 32'hB0 + i);
    check("full_count", o_count, 3'd4);
    issue(32'hA4, 32'hB4, 1'b1);
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (o_free) ok = 1'b0;
    end
    check("stall_no_free", ok, 1'b1);
    check("stall_count", o_count, 3'd4);

    // Release the stall with a single-cycle pop
    @(posedge clk);
    #2 i_ready = 1'b1;
    ok = 1'b0;
    @(negedge clk);
    if (o_free) ok = 1'b1;
    @(posedge clk);
    #2 i_ready = 1'b0;
    @(negedge clk);
    if (o_free) ok = 1'b1;
    check("release_free", ok, 1'b1);
    check("release_count", o_count, 3'd4);
    pop_cycles(4);
    @(negedge clk);
    check("drain_count", o_count, 3'd0);
    check("drain_valid", o_valid, 1'b0);

    // Wrap-around with consumer always ready
    @(posedge clk);
    #2 i_ready = 1'b1;
    max_cnt = 3'd0;
    wrap_phase = 1'b1;
    for (int i = 0; i < 10; i++) send(i, i);
    repeat (2) @(negedge clk);
    wrap_phase = 1'b0;
    @(posedge clk);
    #2 i_ready = 1'b0;
    check("wrap_max_count", max_cnt, 3'd1);
    check("wrap_count", o_count, 3'd0);
    check("wrap_queue_empty", exp_q.size(), 0);

    // Reset one cycle after a drive: request must be dropped
    issue(32'h55, 32'h66, 1'b0);
    @(posedge clk);
    #2 rstn = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b1;
    ok = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (o_free) ok = 1'b0;
    end
    check("rst_no_free", ok, 1'b1);
    check("rst_count", o_count, 3'd0);
    check("rst_valid", o_valid, 1'b0);
    check("rst_data",  o_data,  64'h0);

    send(32'h11, 32'h22);
    check("post_rst_count", o_count, 3'd1);
    check("post_rst_data",  o_data,  64'h00000022_00000011);
    pop_cycles(1);
    @(negedge clk);
    check("post_rst_drained", o_count, 3'd0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
